// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a multi-digit 7-segment display.
// Drives one nibble per slot with dead time, leading-zero blanking and frame-synchronous updates.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [3:0]                data,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      dp,
  output logic                      blank,
  output logic                      frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] P_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

  logic [CW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  nib_t                  pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  nib_t                  shad_v_q, shad_v_d;
  logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;
  logic [3:0]            data_q, data_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  blank_q, blank_d;
  logic                  fd_q, fd_d;

  nib_t                  value_n;
  logic                  wrap;
  logic                  last_dig;
  logic                  frame_edge;
  logic [NUM_DIGITS-1:0] keep;
  logic                  show;
  logic                  active;
  logic                  lit;

  assign value_n = value;

  always_comb begin
    wrap       = (presc_q == P_LAST);
    last_dig   = (idx_q == I_LAST);
    frame_edge = wrap && last_dig;

    presc_d = wrap ? '0 : presc_q + CW'(1);
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = last_dig ? '0 : idx_q + IW'(1);
    end

    pend_v_d  = pend_v_q;
    pend_dp_d = pend_dp_q;
    if (load) begin
      pend_v_d  = value_n;
      pend_dp_d = dp_in;
    end

    // A load on the boundary edge bypasses pending so it is not lost
    shad_v_d  = shad_v_q;
    shad_dp_d = shad_dp_q;
    if (frame_edge) begin
      shad_v_d  = load ? value_n : pend_v_q;
      shad_dp_d = load ? dp_in : pend_dp_q;
    end

    // keep[i]: a nonzero nibble or a decimal point sits at digit i or above
    keep = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      keep[i] = (i == 0)
             || (|(shad_v_d >> (4 * i)))
             || (|(shad_dp_d >> i));
    end

    show   = ~blank_lz | keep[idx_d];
    active = int'(presc_d) >= BLANK_CYCLES;
    lit    = show && active;

    en_d    = lit ? (NUM_DIGITS'(1) << idx_d) : '0;
    blank_d = ~lit;
    data_d  = wrap ? shad_v_d[idx_d] : data_q;
    dp_d    = wrap ? shad_dp_d[idx_d] : dp_q;
    fd_d    = frame_edge;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pend_v_q  <= '0;
      pend_dp_q <= '0;
      shad_v_q  <= '0;
      shad_dp_q <= '0;
      data_q    <= '0;
      dp_q      <= 1'b0;
      en_q      <= '0;
      blank_q   <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pend_v_q  <= pend_v_d;
      pend_dp_q <= pend_dp_d;
      shad_v_q  <= shad_v_d;
      shad_dp_q <= shad_dp_d;
      data_q    <= data_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      blank_q   <= blank_d;
      fd_q      <= fd_d;
    end
  end

  assign data       = data_q;
  assign dp         = dp_q;
  assign digit_en   = en_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed plan plus random loads against a
// cycle-count reference model; a second instance covers CLK_DIV=2, no dead time.
module tb_seg7_scan_mux;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int B  = 2;
  localparam int DN = N * D;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  data;
  logic [3:0]  digit_en;
  logic        dp;
  logic        blank;
  logic        frame_done;

  logic [15:0] value2 = '0;
  logic        load2  = 1'b0;
  logic [3:0]  dp_in2 = '0;
  logic        blz2   = 1'b0;
  logic [3:0]  data2;
  logic [3:0]  en2;
  logic        dp2;
  logic        blank2;
  logic        fd2;

  int errors = 0;
  int checks = 0;

  seg7_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .dp_in(dp_in), .blank_lz(blank_lz), .data(data),
    .digit_en(digit_en), .dp(dp), .blank(blank),
    .frame_done(frame_done)
  );

  seg7_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(2), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .value(value2), .load(load2),
    .dp_in(dp_in2), .blank_lz(blz2), .data(data2),
    .digit_en(en2), .dp(dp2), .blank(blank2),
    .frame_done(fd2)
  );

  always #5 clk = ~clk;

  // Reference: edges since reset, pending and displayed values per frame
  int          m_k;
  logic [15:0] m_pend_v, m_show_v;
  logic [3:0]  m_pend_dp, m_show_dp;
  logic        m_blz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k       <= 0;
      m_pend_v  <= '0;
      m_pend_dp <= '0;
      m_show_v  <= '0;
      m_show_dp <= '0;
      m_blz     <= 1'b0;
    end else begin
      m_k   <= m_k + 1;
      m_blz <= blank_lz;
      if (load) begin
        m_pend_v  <= value;
        m_pend_dp <= dp_in;
      end
      if ((m_k + 1) % DN == 0) begin
        m_show_v  <= load ? value : m_pend_v;
        m_show_dp <= load ? dp_in : m_pend_dp;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int k, c, s;
    logic [3:0] nib;
    logic       supp;
    logic [3:0] en;
    logic [3:0] e2;
    k    = m_k;
    c    = k % D;
    s    = (k / D) % N;
    nib  = 4'((m_show_v >> (4 * s)) & 16'hF);
    supp = m_blz && (s >= 1)
        && ((m_show_v >> (4 * s)) == 16'h0)
        && ((m_show_dp >> s) == 4'h0);
    en   = (k != 0 && c >= B && !supp) ? 4'(1 << s) : 4'h0;
    chk("data", 32'(data), 32'(nib));
    chk("digit_en", 32'(digit_en), 32'(en));
    chk("dp", 32'(dp), 32'(m_show_dp[s]));
    chk("blank", 32'(blank), 32'(en == 4'h0));
    chk("frame_done", 32'(frame_done), 32'(k > 0 && k % DN == 0));
    e2 = (k == 0) ? 4'h0 : 4'(1 << ((k / 2) % 4));
    chk("en2", 32'(en2), 32'(e2));
    chk("blank2", 32'(blank2), 32'(k == 0));
    chk("fd2", 32'(fd2), 32'(k > 0 && k % 8 == 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic align(input int tgt);
    for (int i = 0; i < 2 * DN; i++) begin
      if (m_k % DN == tgt) break;
      step();
    end
  endtask

  // Walks one frame from slot 0 count 0 with fixed expectations
  task automatic scan(input logic [15:0] v, input logic [3:0] enm,
                      input logic [3:0] dpm);
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < D; c++) begin
        if (c == 0) begin
          chk("scan_data", 32'(data), 32'(v[4*s +: 4]));
          chk("scan_dp", 32'(dp), 32'(dpm[s]));
        end
        if (c == 1) chk("scan_dead", 32'(blank), 32'd1);
        if (c == 5)
          chk("scan_en", 32'(digit_en), enm[s] ? 32'(1 << s) : 32'd0);
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [3:0]  dpv;
    int          gap;
    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    dp_in    = '0;
    blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    pulse_load(16'h1234, 4'h0);
    align(0);
    repeat (3) scan(16'h1234, 4'b1111, 4'b0000);

    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'h0);
    align(0);
    scan(16'h0050, 4'b0011, 4'b0000);
    pulse_load(16'h0000, 4'h0);
    align(0);
    scan(16'h0000, 4'b0001, 4'b0000);
    pulse_load(16'h0005, 4'b0100);
    align(0);
    scan(16'h0005, 4'b0111, 4'b0100);

    blank_lz = 1'b0;
    align(0);
    repeat (9) step();
    pulse_load(16'hABCD, 4'h0);
    align(0);
    scan(16'hABCD, 4'b1111, 4'b0000);
    pulse_load(16'h1111, 4'h0);
    repeat (5) step();
    pulse_load(16'h2222, 4'h0);
    align(0);
    scan(16'h2222, 4'b1111, 4'b0000);

    align(DN - 1);
    pulse_load(16'h9876, 4'h0);
    scan(16'h9876, 4'b1111, 4'b0000);

    repeat (2 * D + 4) step();
    reset = 1'b1;
    #1;
    chk("rst_en", 32'(digit_en), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    scan(16'h0000, 4'b1111, 4'b0000);

    for (int it = 0; it < 40; it++) begin
      gap = $urandom_range(0, 40);
      for (int j = 0; j < gap; j++) step();
      if ($urandom_range(0, 3) == 0) blank_lz = ~blank_lz;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        2: v = 16'h0;
        default: ;
      endcase
      dpv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      pulse_load(v, dpv);
    end
    repeat (2 * DN) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed scanner for a common-segment multi-digit 7-segment display. It sits directly upstream of the hex-to-7-segment decoder. It holds a multi-digit hex value and presents one 4-bit nibble per time slot on `data`, which feeds the decoder. At the same time it drives one-hot digit enables, the decimal point and a blank strobe. It applies dead time between digits, optional leading-zero blanking and tear-free frame-synchronous value updates.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 16, dead-time cycles at the start of each slot (0 <= BLANK_CYCLES < CLK_DIV)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
value  input  4*NUM_DIGITS  hex value to display; nibble i is digit i, digit 0 least significant
load  input  1  single-cycle strobe that captures `value`
dp_in  input  NUM_DIGITS  decimal-point request per digit, captured with `value` on `load`
blank_lz  input  1  leading-zero blanking enable (level, sampled live)
data  output  4  nibble for the current digit, to the decoder
digit_en  output  NUM_DIGITS  one-hot digit enable, active-high
dp  output  1  decimal point for the current digit
blank  output  1  high means segments must be forced off (high whenever digit_en == 0)
frame_done  output  1  one-cycle pulse in the first cycle of each new frame

Behaviour:
- Reset (async, active-high) values: data=0, digit_en=0, dp=0, blank=1, frame_done=0. Internals also clear: prescaler=0, digit index=0, pending={value 0, dp 0}, shadow={value 0, dp 0}.
- Prescaler: counts 0..CLK_DIV-1 and wraps. On wrap the digit index advances 0,1,..,NUM_DIGITS-1,0.
- Frame boundary: the edge where prescaler==CLK_DIV-1 and index==NUM_DIGITS-1.
- Capture path:
  - load=1 writes value/dp_in into pending on any edge. With multiple loads in one frame, the last one wins.
  - At the frame boundary, shadow <= pending. If load coincides with the boundary edge, shadow takes the value/dp_in on the bus that cycle directly.
  - The displayed digits therefore never mix two values within one frame.
- Slot outputs: data and dp are registered and change only on the slot-start edge (prescaler wrap). They are computed from the next index and the next shadow. After reset, slot 0 shows shadow digit 0 (=0).
- Enable timing: digit_en[index]=1 for prescaler counts BLANK_CYCLES..CLK_DIV-1 of the slot, and 0 for counts 0..BLANK_CYCLES-1.
  - All outputs are registered, with no combinational paths from inputs.
  - digit_en is never multi-hot.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i >= 1) is suppressed when shadow nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps digit_en=0 and blank=1 for its whole slot.
  - Decimal point: dp=0 for a suppressed digit, unless dp_in for that digit is set. In that case the digit is not suppressed, and the digits below it are not suppressed either.
  - With blank_lz=0, all digits are shown.
- blank = ~|digit_en, cycle-aligned with digit_en.
- frame_done: pulses high for the cycle following each frame-boundary edge. There is no pulse for the first frame after reset.
- Reset mid-slot: outputs go to reset values immediately and asynchronously. Scanning restarts at slot 0, count 0, after deassertion.
- Latency: a load at any point in frame F is shown starting frame F+1. Worst case is one frame plus one cycle.

Test Plan:
1. NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, blank_lz=0; load 0x1234 then run 3 frames.
   - From the next frame: data=4,3,2,1 with digit_en=0001,0010,0100,1000.
   - Each enable is high for exactly 6 cycles after 2 dead cycles, with blank=1 during dead cycles.
   - frame_done pulses every 32 cycles.
2. Load 0x0050 with blank_lz=1.
   - Digits 3 and 2 show digit_en=0 and blank=1 for the whole slot.
   - Digit 1 shows data=5; digit 0 shows data=0 and is enabled.
   - Load 0x0000: only digit 0 is enabled. Set dp_in=0100 with 0x0005: digits 2,1,0 are enabled.
3. Load 0xABCD during slot 1 of frame F: frame F keeps the old digits, and frame F+1 shows D,C,B,A. Load 0x1111 then 0x2222 in the same frame: only 2222 is displayed.
4. Assert load with 0x9876 exactly on the frame-boundary cycle: the frame starting next cycle shows 6,7,8,9.
5. Assert reset at prescaler count 4 of slot 2:
   - Same cycle: digit_en=0, blank=1, data=0, dp=0, frame_done=0.
   - After release, slot 0 begins with count 0 and the display shows 0 until a new load.
6. Set BLANK_CYCLES=0 and CLK_DIV=2. Confirm digit_en is continuously one-hot, rotating every 2 cycles. Confirm blank=0 throughout with blank_lz=0.
